alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single combinational ALU among several requesters in the multi-cycle CPU, such as the PC/branch-target path, the execute stage and the address-generation path. It accepts one operation at a time over a valid/ready handshake. It drives the ALU's op/operand/enable inputs for exactly one cycle, registers the result, and returns it to the granted requester over a second valid/ready handshake.

---
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU among NREQ requesters in the multi-cycle CPU.
// A round-robin search picks one pending request, the operands are registered,
// the ALU is enabled for a single cycle, and the registered result is returned
// to the granted requester over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_op/req_a/req_b    packed per-requester op code and operands
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_data              registered ALU result, owner given by rsp_valid
//   alu_enable/op/a/b     drive the shared ALU
//   alu_ans               ALU result
//   busy                  high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int NREQ = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [4*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_data,
   output logic                 alu_enable,
   output logic [3:0]           alu_op,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   input  logic [31:0]          alu_ans,
   output logic                 busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [IW-1:0]   ptr;      // requester searched first
   logic [IW-1:0]   gnt;      // requester owning the current transaction
   logic [IW-1:0]   sel;      // round-robin winner this cycle
   logic            found;
   logic [3:0]      op_r, sel_op;
   logic [31:0]     a_r, b_r, sel_a, sel_b;

   // Round-robin search: ptr, ptr+1, ... wrapping at NREQ.
   always_comb begin : search
      int idx;
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx[IW-1:0]]) begin
            found = 1'b1;
            sel   = idx[IW-1:0];
         end
      end
   end

   // Operand mux for the winner, using constant slices only.
   always_comb begin : operand_mux
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel == IW'(i)) begin
            sel_op = req_op[4*i +: 4];
            sel_a  = req_a[32*i +: 32];
            sel_b  = req_b[32*i +: 32];
         end
      end
   end

   // Next state and handshake outputs. req_ready never looks at rsp_ready.
   always_comb begin : fsm_next
      state_next = state;
      req_ready  = '0;
      rsp_valid  = '0;
      alu_enable = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               req_ready  = ONE << sel;
               state_next = EXEC;
            end
         end
         EXEC: begin
            alu_enable = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            rsp_valid = ONE << gnt;
            if (rsp_ready[gnt]) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         gnt      <= '0;
         // NOTE: operand and result registers are reset too, so the ALU
         // inputs and rsp_data read as zero immediately on reset.
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         rsp_data <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         state <= state_next;
         if (state == IDLE && found) begin
            gnt  <= sel;
            op_r <= sel_op;
            a_r  <= sel_a;
            b_r  <= sel_b;
         end
         if (state == EXEC) rsp_data <= alu_ans;
         // The requester just served drops to lowest priority.
         if (state == RESP && rsp_ready[gnt])
            ptr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      end
   end

   assign alu_op = op_r;
   assign alu_a  = a_r;
   assign alu_b  = b_r;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter with NREQ=3. A small behavioural ALU answers
// the DUT's ALU port; expected results are hand-computed constants. Inputs are
// driven on the falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int N = 3;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_SLL  = 4'h2;
   localparam logic [3:0] OP_SLT  = 4'h3;
   localparam logic [3:0] OP_SLTU = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_OR   = 4'h8;
   localparam logic [3:0] OP_AND  = 4'h9;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [4*N-1:0]  req_op;
   logic [32*N-1:0] req_a, req_b;
   logic [31:0]     rsp_data, alu_a, alu_b, alu_ans;
   logic [3:0]      alu_op;
   logic            alu_enable, busy;

   int n_vec  = 0;
   int n_miss = 0;

   alu_arbiter #(.NREQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .alu_enable (alu_enable),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ans    (alu_ans),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Shared ALU stand-in; undefined codes yield all ones.
   always_comb begin
      case (alu_op)
         OP_ADD:  alu_ans = alu_a + alu_b;
         OP_SUB:  alu_ans = alu_a - alu_b;
         OP_SLL:  alu_ans = alu_a << alu_b[4:0];
         OP_SLT:  alu_ans = {31'd0, $signed(alu_a) < $signed(alu_b)};
         OP_SLTU: alu_ans = {31'd0, alu_a < alu_b};
         OP_XOR:  alu_ans = alu_a ^ alu_b;
         OP_SRL:  alu_ans = alu_a >> alu_b[4:0];
         OP_SRA:  alu_ans = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         OP_OR:   alu_ans = alu_a | alu_b;
         OP_AND:  alu_ans = alu_a & alu_b;
         default: alu_ans = 32'hFFFF_FFFF;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op[4*i +: 4]  = op;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   // One isolated transaction on requester i; starts and ends at a falling edge
   // with the DUT idle.
   task automatic run_single(input string tag, input int i, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
      logic [N-1:0] oh;
      oh = N'(1) << i;
      set_req(i, op, a, b);
      req_valid = oh;
      rsp_ready = '0;
      #1;
      check({tag, "_req_ready"}, 32'(req_ready), 32'(oh));
      @(negedge clk);
      req_valid = '0;
      #1;
      check({tag, "_exec_en"}, 32'(alu_enable), 32'd1);
      check({tag, "_exec_a"}, alu_a, a);
      check({tag, "_exec_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      #1;
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
      check({tag, "_rsp_data"}, rsp_data, exp);
      check({tag, "_rsp_en"}, 32'(alu_enable), 32'd0);
      rsp_ready = '1;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] cont_exp [N];
      cont_exp[0] = 32'd11;
      cont_exp[1] = 32'd22;
      cont_exp[2] = 32'd33;

      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_alu_en", 32'(alu_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single op and signed/shift ops on distinct requesters.
      run_single("add", 0, OP_ADD, 32'd5, 32'd7, 32'h0000_000C);
      run_single("sub", 1, OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
      run_single("sra", 2, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
      run_single("sltu", 0, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h0000_0001);
      // Served last by requester 2, so the pointer sits at 0 again.
      run_single("xor", 2, OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);

      // Contention: all valid, ready always high, grants 0,1,2,0,1,2.
      set_req(0, OP_ADD, 32'd10, 32'd1);
      set_req(1, OP_ADD, 32'd20, 32'd2);
      set_req(2, OP_ADD, 32'd30, 32'd3);
      req_valid = '1;
      rsp_ready = '1;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("cont%0d_grant", k), 32'(req_ready), 32'(N'(1) << (k % N)));
         @(negedge clk);
         @(negedge clk);
         #1;
         check($sformatf("cont%0d_valid", k), 32'(rsp_valid), 32'(N'(1) << (k % N)));
         check($sformatf("cont%0d_data", k), rsp_data, cont_exp[k % N]);
         @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = '0;

      // Backpressure: requester 0 holds its response while 1 and 2 wait.
      set_req(0, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
      req_valid = 3'b001;
      @(negedge clk);
      req_valid = 3'b110;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'h1);
         check($sformatf("bp%0d_data", k), rsp_data, 32'h0F00_0F00);
         check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
         check($sformatf("bp%0d_en", k), 32'(alu_enable), 32'h0);
         check($sformatf("bp%0d_busy", k), 32'(busy), 32'h1);
         @(negedge clk);
      end
      rsp_ready = 3'b001;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      check("bp_next_grant", 32'(req_ready), 32'b010);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("bp_next_valid", 32'(rsp_valid), 32'b010);
      check("bp_next_data", rsp_data, 32'd22);
      rsp_ready = '1;
      @(negedge clk);
      req_valid = '0;
      rsp_ready = '0;
      @(negedge clk);

      // Reset during EXEC.
      set_req(1, OP_ADD, 32'd100, 32'd23);
      req_valid = 3'b010;
      @(negedge clk);
      req_valid = '0;
      #1;
      check("mid_exec_en", 32'(alu_enable), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_en", 32'(alu_enable), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_op", 32'(alu_op), 32'd0);
      check("mid_rst_a", alu_a, 32'd0);
      check("mid_rst_b", alu_b, 32'd0);
      check("mid_rst_data", rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_rst%0d_valid", k), 32'(rsp_valid), 32'd0);
      end
      run_single("post_rst", 2, OP_SLL, 32'd3, 32'd4, 32'd48);

      // Undefined op code.
      run_single("undef", 0, 4'hF, 32'd1, 32'd1, 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
